// File: rtl/bra_rs.sv
// Branch/jump reservation station.
// The station is an age-ordered queue, and slot 0 always holds the oldest op.
// Each cycle it snoops the CDB for missing operands. It issues the oldest
// operand-complete op to the branch unit through registered bra_* outputs.
// When an op issues, the younger slots move down by one slot at the same edge.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module bra_rs #(
    parameter int DEPTH = 4,
    parameter int ROB_W = `ROB_ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_op,
    input  logic [31:0]                disp_pc,
    input  logic [31:0]                disp_offset,
    input  logic [31:0]                disp_vj,
    input  logic [ROB_W-1:0]           disp_qj,
    input  logic                       disp_rj,
    input  logic [31:0]                disp_vk,
    input  logic [ROB_W-1:0]           disp_qk,
    input  logic                       disp_rk,
    input  logic [ROB_W-1:0]           disp_dest,
    input  logic                       cdb_valid,
    input  logic [ROB_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_val,
    output logic [3:0]                 bra_op,
    output logic [31:0]                bra_src_a,
    output logic [31:0]                bra_src_b,
    output logic [31:0]                bra_pc,
    output logic [31:0]                bra_offset,
    output logic [ROB_W-1:0]           bra_dest,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      pc;
        logic [31:0]      offset;
        logic [31:0]      vj;
        logic [ROB_W-1:0] qj;
        logic             rj;
        logic [31:0]      vk;
        logic [ROB_W-1:0] qk;
        logic             rk;
        logic [ROB_W-1:0] dest;
    } slot_t;

    slot_t            slot_r [DEPTH];
    logic [CW-1:0]    count_r;

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] ready_s;
    logic             sel_found_s;
    logic [IW-1:0]    sel_idx_s;
    slot_t            wake_s [DEPTH+1];   // the extra top element is an empty filler used during compaction
    slot_t            nxt_s [DEPTH];
    slot_t            disp_entry_s;
    logic             disp_fire_s;
    logic [CW-1:0]    wr_idx_s;
    logic [CW-1:0]    count_nxt_s;

    assign disp_ready = (count_r < CW'(DEPTH));
    assign count      = count_r;

    // Decide which slots are occupied and which have both operands at cycle start.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = (CW'(i) < count_r);
            ready_s[i] = valid_s[i] & slot_r[i].rj & slot_r[i].rk;
        end
    end

    // Pick the oldest ready slot, which is the lowest index.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_s[i] && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Apply the CDB wakeup to every waiting operand of the stored slots.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake_s[i] = slot_r[i];
            if (cdb_valid && valid_s[i] && !slot_r[i].rj && (slot_r[i].qj == cdb_tag)) begin
                wake_s[i].vj = cdb_val;
                wake_s[i].rj = 1'b1;
            end else begin
                wake_s[i].rj = slot_r[i].rj;
            end
            if (cdb_valid && valid_s[i] && !slot_r[i].rk && (slot_r[i].qk == cdb_tag)) begin
                wake_s[i].vk = cdb_val;
                wake_s[i].rk = 1'b1;
            end else begin
                wake_s[i].rk = slot_r[i].rk;
            end
        end
        wake_s[DEPTH] = '0;
    end

    // Build the incoming entry. A broadcast in the same cycle is captured here so the wakeup is not lost.
    always_comb begin
        disp_entry_s        = '0;
        disp_entry_s.op     = disp_op;
        disp_entry_s.pc     = disp_pc;
        disp_entry_s.offset = disp_offset;
        disp_entry_s.qj     = disp_qj;
        disp_entry_s.qk     = disp_qk;
        disp_entry_s.dest   = disp_dest;
        if (!disp_rj && cdb_valid && (disp_qj == cdb_tag)) begin
            disp_entry_s.vj = cdb_val;
            disp_entry_s.rj = 1'b1;
        end else begin
            disp_entry_s.vj = disp_vj;
            disp_entry_s.rj = disp_rj;
        end
        if (!disp_rk && cdb_valid && (disp_qk == cdb_tag)) begin
            disp_entry_s.vk = cdb_val;
            disp_entry_s.rk = 1'b1;
        end else begin
            disp_entry_s.vk = disp_vk;
            disp_entry_s.rk = disp_rk;
        end
    end

    // Compact above the issued slot, write the new entry behind the youngest survivor, and update the occupancy.
    always_comb begin
        disp_fire_s = disp_valid & disp_ready;
        wr_idx_s    = count_r - CW'(sel_found_s);
        count_nxt_s = count_r + CW'(disp_fire_s) - CW'(sel_found_s);
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire_s && (wr_idx_s == CW'(i))) begin
                nxt_s[i] = disp_entry_s;
            end else if (sel_found_s && (IW'(i) >= sel_idx_s)) begin
                nxt_s[i] = wake_s[i+1];
            end else begin
                nxt_s[i] = wake_s[i];
            end
        end
    end

    // State and issue registers. A flush empties the queue and cancels the issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
            count_r    <= '0;
            bra_op     <= 4'd0;
            bra_src_a  <= 32'd0;
            bra_src_b  <= 32'd0;
            bra_pc     <= 32'd0;
            bra_offset <= 32'd0;
            bra_dest   <= '0;
        end else if (flush) begin
            count_r <= '0;
            bra_op  <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= nxt_s[i];
            end
            count_r <= count_nxt_s;
            if (sel_found_s) begin
                bra_op     <= slot_r[sel_idx_s].op;
                bra_src_a  <= slot_r[sel_idx_s].vj;
                bra_src_b  <= slot_r[sel_idx_s].vk;
                bra_pc     <= slot_r[sel_idx_s].pc;
                bra_offset <= slot_r[sel_idx_s].offset;
                bra_dest   <= slot_r[sel_idx_s].dest;
            end else begin
                bra_op <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// Directed bench for bra_rs. It uses hand-computed expectations for issue order, wakeup, bypass, flush and reset.
module tb_bra_rs;

    localparam int DEPTH = 4;
    localparam int ROB_W = 4;

    localparam logic [3:0] BEQ  = 4'd1;
    localparam logic [3:0] BNE  = 4'd2;
    localparam logic [3:0] BLT  = 4'd3;
    localparam logic [3:0] BGE  = 4'd4;
    localparam logic [3:0] BLTU = 4'd5;
    localparam logic [3:0] BGEU = 4'd6;
    localparam logic [3:0] JAL  = 4'd7;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_op;
    logic [31:0]      disp_pc;
    logic [31:0]      disp_offset;
    logic [31:0]      disp_vj;
    logic [ROB_W-1:0] disp_qj;
    logic             disp_rj;
    logic [31:0]      disp_vk;
    logic [ROB_W-1:0] disp_qk;
    logic             disp_rk;
    logic [ROB_W-1:0] disp_dest;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic [3:0]       bra_op;
    logic [31:0]      bra_src_a;
    logic [31:0]      bra_src_b;
    logic [31:0]      bra_pc;
    logic [31:0]      bra_offset;
    logic [ROB_W-1:0] bra_dest;
    logic [2:0]       count;

    int n_vec;
    int n_err;

    bra_rs #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_pc(disp_pc), .disp_offset(disp_offset),
        .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_rj(disp_rj),
        .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_rk(disp_rk),
        .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .bra_op(bra_op), .bra_src_a(bra_src_a), .bra_src_b(bra_src_b),
        .bra_pc(bra_pc), .bra_offset(bra_offset), .bra_dest(bra_dest),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] off,
                        input logic [31:0] vj, input logic [3:0] qj, input logic rj,
                        input logic [31:0] vk, input logic [3:0] qk, input logic rk,
                        input logic [3:0] dest);
        disp_valid  = 1'b1;
        disp_op     = op;
        disp_pc     = pc;
        disp_offset = off;
        disp_vj     = vj;
        disp_qj     = qj;
        disp_rj     = rj;
        disp_vk     = vk;
        disp_qk     = qk;
        disp_rk     = rk;
        disp_dest   = dest;
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_val   = val;
    endtask

    task automatic chk_issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] pc, input logic [3:0] dest);
        check({tag, ".op"},   32'(bra_op),   32'(op));
        check({tag, ".a"},    bra_src_a,     a);
        check({tag, ".b"},    bra_src_b,     b);
        check({tag, ".pc"},   bra_pc,        pc);
        check({tag, ".dest"}, 32'(bra_dest), 32'(dest));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        disp_op = 4'd0; disp_pc = 32'd0; disp_offset = 32'd0;
        disp_vj = 32'd0; disp_qj = 4'd0; disp_rj = 1'b0;
        disp_vk = 32'd0; disp_qk = 4'd0; disp_rk = 1'b0; disp_dest = 4'd0;
        cdb_tag = 4'd0; cdb_val = 32'd0;
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.ready", 32'(disp_ready), 32'd1);
        check("rst.op", 32'(bra_op), 32'd0);
        check("rst.pc", bra_pc, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: ready BEQ issues one cycle after dispatch, for exactly one cycle
        disp(BEQ, 32'h100, 32'h20, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 1'b1, 4'd1);
        step();
        idle();
        check("t1.count", 32'(count), 32'd1);
        check("t1.op0", 32'(bra_op), 32'd0);
        step();
        chk_issue("t1.iss", BEQ, 32'h11, 32'h22, 32'h100, 4'd1);
        check("t1.off", bra_offset, 32'h20);
        check("t1.count0", 32'(count), 32'd0);
        step();
        check("t1.op_clr", 32'(bra_op), 32'd0);
        check("t1.pc_hold", bra_pc, 32'h100);

        // 2: BNE waits on tag 3 and issues one cycle after the broadcast
        disp(BNE, 32'h200, 32'h8, 32'h0, 4'd3, 1'b0, 32'h66, 4'd0, 1'b1, 4'd2);
        step();
        idle();
        step();
        check("t2.wait", 32'(bra_op), 32'd0);
        bcast(4'd3, 32'h55);
        step();
        idle();
        check("t2.nobypass", 32'(bra_op), 32'd0);
        step();
        chk_issue("t2.iss", BNE, 32'h55, 32'h66, 32'h200, 4'd2);

        // 3: full station with oldest blocked; younger ones issue in age order
        disp(BLT,  32'h300, 32'h4, 32'h0,  4'd5, 1'b0, 32'hA0, 4'd0, 1'b1, 4'd4);
        step();
        disp(BGE,  32'h304, 32'h4, 32'h31, 4'd0, 1'b1, 32'h0,  4'd6, 1'b0, 4'd5);
        step();
        disp(BLTU, 32'h308, 32'h4, 32'h32, 4'd0, 1'b1, 32'h0,  4'd6, 1'b0, 4'd6);
        step();
        disp(BGEU, 32'h30C, 32'h4, 32'h33, 4'd0, 1'b1, 32'h0,  4'd6, 1'b0, 4'd7);
        step();
        check("t3.full.count", 32'(count), 32'd4);
        check("t3.full.ready", 32'(disp_ready), 32'd0);
        disp(BEQ, 32'h3F0, 32'h4, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'd8);
        step();
        idle();
        check("t3.ignored", 32'(count), 32'd4);
        check("t3.noissue", 32'(bra_op), 32'd0);
        bcast(4'd6, 32'h77);
        step();
        idle();
        check("t3.woke.op", 32'(bra_op), 32'd0);
        check("t3.woke.ready", 32'(disp_ready), 32'd0);
        step();
        chk_issue("t3.i1", BGE, 32'h31, 32'h77, 32'h304, 4'd5);
        check("t3.i1.count", 32'(count), 32'd3);
        check("t3.i1.ready", 32'(disp_ready), 32'd1);
        step();
        chk_issue("t3.i2", BLTU, 32'h32, 32'h77, 32'h308, 4'd6);
        step();
        chk_issue("t3.i3", BGEU, 32'h33, 32'h77, 32'h30C, 4'd7);
        check("t3.i3.count", 32'(count), 32'd1);
        bcast(4'd5, 32'h5A);
        step();
        idle();
        check("t3.oldwait", 32'(bra_op), 32'd0);
        step();
        chk_issue("t3.i0", BLT, 32'h5A, 32'hA0, 32'h300, 4'd4);
        check("t3.empty", 32'(count), 32'd0);
        step();
        check("t3.none", 32'(bra_op), 32'd0);

        // 4: dispatch bypass from the CDB on both operands; then dispatch and issue in the same cycle
        disp(JAL, 32'h400, 32'h40, 32'h0, 4'd7, 1'b0, 32'h0, 4'd7, 1'b0, 4'd9);
        bcast(4'd7, 32'h9);
        step();
        idle();
        check("t4.count", 32'(count), 32'd1);
        check("t4.op0", 32'(bra_op), 32'd0);
        disp(BEQ, 32'h410, 32'h10, 32'hC1, 4'd0, 1'b1, 32'hC2, 4'd0, 1'b1, 4'd10);
        step();
        idle();
        chk_issue("t4.iss", JAL, 32'h9, 32'h9, 32'h400, 4'd9);
        check("t4.samecyc.count", 32'(count), 32'd1);
        step();
        chk_issue("t4.iss2", BEQ, 32'hC1, 32'hC2, 32'h410, 4'd10);
        check("t4.count0", 32'(count), 32'd0);

        // 5: flush a full station with a ready entry and a dispatch pending
        for (int i = 0; i < 4; i++) begin
            disp(BNE, 32'h500 + 32'(i * 4), 32'h4, 32'h0, 4'd8, 1'b0, 32'h2, 4'd0, 1'b1, 4'(i));
            step();
        end
        idle();
        check("t5.full", 32'(count), 32'd4);
        bcast(4'd8, 32'h88);
        step();
        idle();
        flush = 1'b1;
        disp(BEQ, 32'h5F0, 32'h4, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'd3);
        step();
        idle();
        check("t5.count", 32'(count), 32'd0);
        check("t5.op", 32'(bra_op), 32'd0);
        step();
        check("t5.after", 32'(bra_op), 32'd0);
        flush = 1'b1;
        disp(BEQ, 32'h5E0, 32'h4, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'd3);
        step();
        idle();
        check("t5.drop.count", 32'(count), 32'd0);
        step();
        check("t5.drop.op", 32'(bra_op), 32'd0);
        disp(BGE, 32'h580, 32'h8, 32'hD1, 4'd0, 1'b1, 32'hD2, 4'd0, 1'b1, 4'd11);
        step();
        idle();
        check("t5.slot0", 32'(count), 32'd1);
        step();
        chk_issue("t5.iss", BGE, 32'hD1, 32'hD2, 32'h580, 4'd11);

        // 6: asynchronous reset while entries pend and an op is being issued
        for (int i = 0; i < 3; i++) begin
            disp(BLT, 32'h600 + 32'(i * 4), 32'h4, 32'h0, 4'd9, 1'b0, 32'h3, 4'd0, 1'b1, 4'(i));
            step();
        end
        disp(BEQ, 32'h60C, 32'h4, 32'hE1, 4'd0, 1'b1, 32'hE2, 4'd0, 1'b1, 4'd12);
        step();
        check("t6.full", 32'(count), 32'd4);
        disp(BNE, 32'h610, 32'h4, 32'h0, 4'd9, 1'b0, 32'h3, 4'd0, 1'b1, 4'd13);
        step();
        idle();
        chk_issue("t6.iss", BEQ, 32'hE1, 32'hE2, 32'h60C, 4'd12);
        check("t6.fullrule", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t6.rst.op", 32'(bra_op), 32'd0);
        check("t6.rst.a", bra_src_a, 32'd0);
        check("t6.rst.b", bra_src_b, 32'd0);
        check("t6.rst.pc", bra_pc, 32'd0);
        check("t6.rst.off", bra_offset, 32'd0);
        check("t6.rst.dest", 32'(bra_dest), 32'd0);
        check("t6.rst.count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        bcast(4'd9, 32'h99);
        step();
        idle();
        check("t6.post.count", 32'(count), 32'd0);
        check("t6.post.ready", 32'(disp_ready), 32'd1);
        step();
        check("t6.post.op", 32'(bra_op), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
